// File: rtl/apb_rom_arbiter_if.sv
// ----------------------------------------------------------------------------
// apb_rom_arbiter_if
// Bundles the two requester channels and the APB master port of
// apb_rom_arbiter.
//   reqN_valid/reqN_addr  : read request from requester N (N = 0, 1)
//   reqN_ready            : request accepted this cycle
//   rspN_valid/rspN_err   : one-cycle response pulse and its error flag
//   rsp_data              : read data of the most recent response
//   m_psel ... m_pready   : APB read-only master toward the ROM slave
// Modports:
//   master : arbiter view (drives ready/response and the APB request)
//   slave  : environment view (requesters and the ROM slave)
// ----------------------------------------------------------------------------
interface apb_rom_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_addr;
    logic        req0_ready;
    logic        rsp0_valid;
    logic        rsp0_err;
    logic        req1_valid;
    logic [15:0] req1_addr;
    logic        req1_ready;
    logic        rsp1_valid;
    logic        rsp1_err;
    logic [15:0] rsp_data;
    logic        m_psel;
    logic        m_penable;
    logic [15:0] m_paddr;
    logic        m_pwrite;
    logic [15:0] m_pwdata;
    logic [15:0] m_prdata;
    logic        m_pready;

    modport master (
        input  req0_valid, req0_addr, req1_valid, req1_addr, m_prdata, m_pready,
        output req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err,
               rsp_data, m_psel, m_penable, m_paddr, m_pwrite, m_pwdata
    );

    modport slave (
        output req0_valid, req0_addr, req1_valid, req1_addr, m_prdata, m_pready,
        input  req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err,
               rsp_data, m_psel, m_penable, m_paddr, m_pwrite, m_pwdata
    );
endinterface

// File: rtl/apb_rom_arbiter.sv
// ----------------------------------------------------------------------------
// apb_rom_arbiter
// Round-robin arbiter letting two read requesters share one APB ROM slave.
// A request is accepted combinationally in IDLE, then runs a SETUP cycle and
// an ACCESS phase that ends when the slave raises m_pready. The read data is
// registered into rsp_data and the owner gets a one-cycle rspN_valid pulse.
// Ports:
//   pclk   : clock, all logic on the rising edge
//   preset : synchronous active-low reset
//   bus    : apb_rom_arbiter_if.master (requester channels + APB master)
// Parameter:
//   TIMEOUT : ACCESS-cycle limit before the transfer is aborted
// Build option:
//   APB_ARB_TIMEOUT_EN : when defined, an ACCESS phase lasting TIMEOUT cycles
//   without m_pready is aborted with an error response and rsp_data = 0.
//   When undefined, ACCESS waits indefinitely and rspN_err is tied to 0.
// ----------------------------------------------------------------------------
module apb_rom_arbiter #(
    parameter int TIMEOUT = 16
) (
    input logic               pclk,
    input logic               preset,
    apb_rom_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    // A non-positive limit would make every transfer abort immediately.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("apb_rom_arbiter: TIMEOUT must be at least 1");
    end

    state_t      state_r;
    state_t      state_s;
    logic        grant_vld_s;
    logic        grant_id_s;
    logic        done_s;
    logic        abort_s;
    logic        last_grant_r;
    logic        owner_r;
    logic [15:0] addr_r;
    logic        psel_r;
    logic        penable_r;
    logic        rsp0_valid_r;
    logic        rsp1_valid_r;
    logic [15:0] rsp_data_r;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             rsp0_err_r;
    logic             rsp1_err_r;
`endif

    // Round-robin winner selection; only offered in IDLE and out of reset.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        if ((state_r == IDLE) && preset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_vld_s = 1'b1;
                grant_id_s  = ~last_grant_r;
            end else if (bus.req0_valid) begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b1;
            end else begin
                grant_vld_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        end else begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
        end
    end

    // Next-state logic; done_s/abort_s flag the edge that ends ACCESS.
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        abort_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_vld_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s = ACCESS;
            end
            ACCESS: begin
                // m_pready wins over the limit when both occur on one edge.
                if (bus.m_pready) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                end else if (cnt_r == LIMIT) begin
                    state_s = IDLE;
                    abort_s = 1'b1;
`endif
                end else begin
                    state_s = ACCESS;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched request, APB strobes and response registers.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            addr_r       <= 16'h0000;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp_data_r   <= 16'h0000;
        end else begin
            state_r   <= state_s;
            // Strobes follow the state being entered so they are glitch-free.
            psel_r    <= (state_s == SETUP) || (state_s == ACCESS);
            penable_r <= (state_s == ACCESS);
            if (grant_vld_s) begin
                addr_r       <= grant_id_s ? bus.req1_addr : bus.req0_addr;
                owner_r      <= grant_id_s;
                last_grant_r <= grant_id_s;
            end else begin
                addr_r       <= addr_r;
                owner_r      <= owner_r;
                last_grant_r <= last_grant_r;
            end
            rsp0_valid_r <= (done_s | abort_s) & ~owner_r;
            rsp1_valid_r <= (done_s | abort_s) & owner_r;
            if (done_s) begin
                rsp_data_r <= bus.m_prdata;
            end else if (abort_s) begin
                rsp_data_r <= 16'h0000;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // ACCESS-cycle counter and error flags for the abort path.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            cnt_r      <= {CNT_W{1'b0}};
            rsp0_err_r <= 1'b0;
            rsp1_err_r <= 1'b0;
        end else begin
            if ((state_r == ACCESS) && (state_s == ACCESS)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            rsp0_err_r <= abort_s & ~owner_r;
            rsp1_err_r <= abort_s & owner_r;
        end
    end

    assign bus.rsp0_err = rsp0_err_r;
    assign bus.rsp1_err = rsp1_err_r;
`else
    assign bus.rsp0_err = 1'b0;
    assign bus.rsp1_err = 1'b0;
`endif

    assign bus.req0_ready = grant_vld_s & ~grant_id_s;
    assign bus.req1_ready = grant_vld_s & grant_id_s;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.m_psel     = psel_r;
    assign bus.m_penable  = penable_r;
    assign bus.m_paddr    = addr_r;
    assign bus.m_pwrite   = 1'b0;
    assign bus.m_pwdata   = 16'h0000;

endmodule

// File: tb/tb_apb_rom_arbiter.sv
// ----------------------------------------------------------------------------
// tb_apb_rom_arbiter
// Random requesters, random slave wait states and random resets, checked
// against a transaction-timeline model: a request accepted in cycle k with w
// slave wait states shows SETUP in k+1, ACCESS in k+2..k+2+w and its response
// in k+3+w (or an error response in k+2+TIMEOUT when the timeout option is
// built in and w >= TIMEOUT).
// ----------------------------------------------------------------------------
module tb_apb_rom_arbiter;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic preset;

    apb_rom_arbiter_if bus();

    apb_rom_arbiter #(.TIMEOUT(TO)) dut (
        .pclk   (clk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rom(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Reference model state
    bit          m_busy;
    int          m_k, m_w, m_due;
    bit          m_owner, m_err;
    logic [15:0] m_addr;
    bit          last_g;
    logic [15:0] exp_data, exp_paddr;
    // Requester state
    bit          pend0, pend1;
    logic [15:0] a0, a1;

    initial begin
        bit in_txn, rsp_now, g_vld, g_id;
        int r;
        preset = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_addr = 16'h0000;
        bus.req1_valid = 1'b0; bus.req1_addr = 16'h0000;
        bus.m_pready = 1'b0;   bus.m_prdata = 16'h0000;
        m_busy = 1'b0; m_k = 0; m_w = 0; m_due = 0; m_owner = 1'b0; m_err = 1'b0;
        m_addr = 16'h0000; last_g = 1'b1; exp_data = 16'h0000; exp_paddr = 16'h0000;
        pend0 = 1'b0; pend1 = 1'b0; a0 = 16'h0000; a1 = 16'h0000;

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            in_txn  = m_busy && (cyc < m_due);
            rsp_now = m_busy && (cyc == m_due);

            // Reset for the first cycles, then occasional random resets.
            preset = !((cyc < 3) || ((cyc >= 20) && ($urandom_range(0, 149) == 0)));

            // Requesters: directed req0 read of 0x0010 at cycle 3, then random.
            if (!pend0 && ((cyc == 3) || ((cyc >= 20) && ($urandom_range(0, 3) != 0)))) begin
                pend0 = 1'b1;
                a0 = (cyc == 3) ? 16'h0010 : 16'($urandom_range(0, 63));
            end
            if (!pend1 && (cyc >= 20) && ($urandom_range(0, 3) != 0)) begin
                pend1 = 1'b1;
                a1 = 16'($urandom_range(0, 63));
            end
            bus.req0_valid = pend0;
            bus.req0_addr  = pend0 ? a0 : 16'($urandom);
            bus.req1_valid = pend1;
            bus.req1_addr  = pend1 ? a1 : 16'($urandom);

            // ROM slave: ready after m_w ACCESS cycles, noise when not selected.
            if (in_txn && (cyc == m_k + 2 + m_w)) begin
                bus.m_pready = 1'b1;
                bus.m_prdata = rom(m_addr);
            end else if (in_txn && (cyc >= m_k + 2)) begin
                bus.m_pready = 1'b0;
                bus.m_prdata = 16'($urandom);
            end else begin
                bus.m_pready = 1'($urandom);
                bus.m_prdata = 16'($urandom);
            end

            // Expected grant for this cycle.
            g_vld = preset && !in_txn && (pend0 || pend1);
            g_id  = (pend0 && pend1) ? !last_g : pend1;
            if (rsp_now) exp_data = m_err ? 16'h0000 : rom(m_addr);

            #4;
            if (cyc > 0) begin
                check_eq("ready0",  16'(bus.req0_ready), 16'(g_vld && !g_id));
                check_eq("ready1",  16'(bus.req1_ready), 16'(g_vld && g_id));
                check_eq("rsp0_valid", 16'(bus.rsp0_valid), 16'(rsp_now && !m_owner));
                check_eq("rsp1_valid", 16'(bus.rsp1_valid), 16'(rsp_now && m_owner));
                check_eq("rsp0_err", 16'(bus.rsp0_err), 16'(rsp_now && m_err && !m_owner));
                check_eq("rsp1_err", 16'(bus.rsp1_err), 16'(rsp_now && m_err && m_owner));
                check_eq("rsp_data", bus.rsp_data, exp_data);
                check_eq("psel",    16'(bus.m_psel), 16'(in_txn));
                check_eq("penable", 16'(bus.m_penable), 16'(in_txn && (cyc >= m_k + 2)));
                check_eq("paddr",   bus.m_paddr, exp_paddr);
                check_eq("pwrite",  16'(bus.m_pwrite), 16'h0000);
                check_eq("pwdata",  bus.m_pwdata, 16'h0000);
            end

            // Advance the model across the coming rising edge.
            if (!preset) begin
                m_busy    = 1'b0;
                last_g    = 1'b1;
                exp_data  = 16'h0000;
                exp_paddr = 16'h0000;
            end else begin
                if (rsp_now) m_busy = 1'b0;
                if (g_vld) begin
                    m_busy    = 1'b1;
                    m_k       = cyc;
                    m_owner   = g_id;
                    m_addr    = g_id ? a1 : a0;
                    last_g    = g_id;
                    exp_paddr = m_addr;
                    if (cyc < 20) begin
                        m_w = 0;
                    end else begin
                        r = $urandom_range(0, 29);
                        if (r == 0)      m_w = $urandom_range(TO, TO + 4);
                        else if (r == 1) m_w = TO - 1;
                        else             m_w = r % 4;
                    end
                    m_due = m_k + 3 + m_w;
                    m_err = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
                    if (m_w >= TO) begin
                        m_due = m_k + 2 + TO;
                        m_err = 1'b1;
                    end
`endif
                    if (g_id) pend1 = 1'b0;
                    else      pend0 = 1'b0;
                end
            end
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
